csa8_seq_core: RTL and testbench



---
 rtl/csa8_seq_core.sv | 175 +++++++++++++++++
 tb/tb_csa8_seq_core.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/csa8_seq_core.sv
// csa8_seq_core: sequential front-end/back-end for an 8-bit carry-select adder.
// Operands A and B are loaded one after the other over ui_in, each with a
// strobe on uio_in[0]. The sum or difference goes through a two-stage
// carry-select pipeline: the low nibble first, then the high nibble.
// The result stays on uo_out, with a valid flag, until the next
// transaction starts.
// Optional build macro: CSA8_SAT_EN. When it is defined, a signed overflow
// saturates the result to 0x7F or 0x80.

module csa8_seq_core #(
    parameter int NIB = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int W = 2 * NIB;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_B  = 2'd1,
        CALC_LO = 2'd2,
        CALC_HI = 2'd3
    } state_t;

    state_t state, next_state;

    logic         strobe_q;
    logic [W-1:0] a_q, b_q;
    logic         sub_q;
    logic [NIB-1:0] lo_q;
    logic           c4_q;
    logic [NIB:0]   hi0_q, hi1_q;
    logic [W-1:0] result_q;
    logic         cout_q, ovf_q, valid_q;

    logic load_ev, clear;
    logic load_a, load_b, do_lo, do_hi;

    logic [W-1:0] b_eff;
    logic [NIB:0] lo_full, hi0_n, hi1_n, hi_sel;
    logic [W-1:0] sum_n, result_n;
    logic         ovf_n;

    logic unused_uio;
    assign unused_uio = ^uio_in[7:3];

    assign load_ev = uio_in[0] & ~strobe_q & ena;
    assign clear   = uio_in[2] & ena;

    // Edge detector on the load strobe. It follows the pin only while the tile is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            strobe_q <= 1'b0;
        else if (ena)
            strobe_q <= uio_in[0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic and datapath enables. A clear overrides any load event on the same edge.
    always_comb begin
        next_state = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        do_lo      = 1'b0;
        do_hi      = 1'b0;
        if (ena) begin
            if (clear) begin
                next_state = IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (load_ev) begin
                            load_a     = 1'b1;
                            next_state = WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        if (load_ev) begin
                            load_b     = 1'b1;
                            next_state = CALC_LO;
                        end
                    end
                    CALC_LO: begin
                        do_lo      = 1'b1;
                        next_state = CALC_HI;
                    end
                    CALC_HI: begin
                        do_hi      = 1'b1;
                        next_state = IDLE;
                    end
                    default: next_state = IDLE;
                endcase
            end
        end
    end

    // Carry-select arithmetic. Subtraction inverts B and injects a carry-in of 1.
    // Both high-nibble candidates are formed in the same cycle as the low nibble.
    always_comb begin
        b_eff    = sub_q ? ~b_q : b_q;
        lo_full  = {1'b0, a_q[NIB-1:0]} + {1'b0, b_eff[NIB-1:0]} + {{NIB{1'b0}}, sub_q};
        hi0_n    = {1'b0, a_q[W-1:NIB]} + {1'b0, b_eff[W-1:NIB]};
        hi1_n    = {1'b0, a_q[W-1:NIB]} + {1'b0, b_eff[W-1:NIB]} + {{NIB{1'b0}}, 1'b1};
        hi_sel   = c4_q ? hi1_q : hi0_q;
        sum_n    = {hi_sel[NIB-1:0], lo_q};
        ovf_n    = (a_q[W-1] == b_eff[W-1]) && (sum_n[W-1] != a_q[W-1]);
`ifdef CSA8_SAT_EN
        if (ovf_n)
            result_n = a_q[W-1] ? 8'h80 : 8'h7F;
        else
            result_n = sum_n;
`else
        result_n = sum_n;
`endif
    end

    // Operand capture, the pipeline stages and the result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            lo_q     <= '0;
            c4_q     <= 1'b0;
            hi0_q    <= '0;
            hi1_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (ena && clear)
                valid_q <= 1'b0;
            if (load_a) begin
                a_q     <= ui_in;
                valid_q <= 1'b0;
            end
            if (load_b) begin
                b_q   <= ui_in;
                sub_q <= uio_in[1];
            end
            if (do_lo) begin
                lo_q  <= lo_full[NIB-1:0];
                c4_q  <= lo_full[NIB];
                hi0_q <= hi0_n;
                hi1_q <= hi1_n;
            end
            if (do_hi) begin
                result_q <= result_n;
                cout_q   <= hi_sel[NIB];
                ovf_q    <= ovf_n;
                valid_q  <= 1'b1;
            end
        end
    end

    assign uo_out  = result_q;
    assign uio_out = {ovf_q, cout_q, (state == WAIT_B), valid_q, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_csa8_seq_core.sv
// tb_csa8_seq_core: directed vector table plus hand-written corner sequences
// for csa8_seq_core. Expected results follow CSA8_SAT_EN when it is defined.

module tb_csa8_seq_core;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] res;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[7];

    csa8_seq_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Free-running clock; stimulus changes and sampling happen on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One strobe pulse with data on ui_in, followed by one low cycle so the edge detector rearms.
    task automatic strobe(input logic [7:0] data, input logic sub);
        ui_in  = data;
        uio_in = {6'b0, sub, 1'b1};
        tick(1);
        uio_in = 8'h00;
        tick(1);
    endtask

    task automatic check_output(input string tag, input logic [7:0] res, input logic cout, input logic ovf);
        check({tag, "_res"},   uo_out, res);
        check({tag, "_cout"},  {7'b0, uio_out[6]}, {7'b0, cout});
        check({tag, "_ovf"},   {7'b0, uio_out[7]}, {7'b0, ovf});
        check({tag, "_valid"}, {7'b0, uio_out[4]}, 8'h01);
        check({tag, "_waitb"}, {7'b0, uio_out[5]}, 8'h00);
        check({tag, "_low"},   {4'b0, uio_out[3:0]}, 8'h00);
        check({tag, "_oe"},    uio_oe, 8'hF0);
    endtask

    // Full transaction. After strobe(B) returns, one edge has passed since B was captured.
    task automatic apply_stimulus(input string tag, input vec_t v);
        strobe(v.a, 1'b0);
        check({tag, "_waitb_set"}, {7'b0, uio_out[5]}, 8'h01);
        strobe(v.b, v.sub);
        check({tag, "_valid_early"}, {7'b0, uio_out[4]}, 8'h00);
        tick(1);
        check_output(tag, v.res, v.cout, v.ovf);
    endtask

    initial begin
        vecs[0] = '{a: 8'h3C, b: 8'h5A, sub: 1'b0,
`ifdef CSA8_SAT_EN
                    res: 8'h7F,
`else
                    res: 8'h96,
`endif
                    cout: 1'b0, ovf: 1'b1};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, res: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h0F, b: 8'h01, sub: 1'b0, res: 8'h10, cout: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 8'h10, b: 8'h20, sub: 1'b1, res: 8'hF0, cout: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 8'h20, b: 8'h10, sub: 1'b1, res: 8'h10, cout: 1'b1, ovf: 1'b0};
        vecs[5] = '{a: 8'h80, b: 8'h01, sub: 1'b1,
`ifdef CSA8_SAT_EN
                    res: 8'h80,
`else
                    res: 8'h7F,
`endif
                    cout: 1'b1, ovf: 1'b1};
        vecs[6] = '{a: 8'h7F, b: 8'h01, sub: 1'b0,
`ifdef CSA8_SAT_EN
                    res: 8'h7F,
`else
                    res: 8'h80,
`endif
                    cout: 1'b0, ovf: 1'b1};

        // Outputs under reset.
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        check("rst_uo",  uo_out,  8'h00);
        check("rst_uio", uio_out, 8'h00);
        check("rst_oe",  uio_oe,  8'hF0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Table-driven arithmetic vectors.
        for (int i = 0; i < 7; i++)
            apply_stimulus($sformatf("vec%0d", i), vecs[i]);

        // A strobe held high for five cycles loads A only. The old result stays on uo_out.
        ui_in  = 8'h33;
        uio_in = 8'h01;
        tick(1);
        ui_in  = 8'h44;
        tick(4);
        check("hold_waitb", {7'b0, uio_out[5]}, 8'h01);
        check("hold_valid", {7'b0, uio_out[4]}, 8'h00);
        check("hold_uo",    uo_out, vecs[6].res);
        uio_in = 8'h00;
        tick(1);

        // A clear together with a new strobe returns to IDLE without capturing B.
        ui_in  = 8'h55;
        uio_in = 8'h05;
        tick(1);
        check("clr_waitb", {7'b0, uio_out[5]}, 8'h00);
        check("clr_valid", {7'b0, uio_out[4]}, 8'h00);
        uio_in = 8'h00;
        tick(3);
        check("clr_nocalc_valid", {7'b0, uio_out[4]}, 8'h00);
        check("clr_nocalc_uo",    uo_out, vecs[6].res);
        check("clr_oe",           uio_oe, 8'hF0);

        // With ena low, a strobe in WAIT_B is ignored.
        strobe(8'h12, 1'b0);
        check("ena_waitb0", {7'b0, uio_out[5]}, 8'h01);
        ena    = 1'b0;
        ui_in  = 8'h55;
        uio_in = 8'h01;
        tick(1);
        uio_in = 8'h00;
        tick(2);
        check("ena_waitb1", {7'b0, uio_out[5]}, 8'h01);
        check("ena_valid",  {7'b0, uio_out[4]}, 8'h00);
        ena = 1'b1;
        tick(1);
        strobe(8'h34, 1'b0);
        tick(1);
        check_output("ena_sum", 8'h46, 1'b0, 1'b0);

        // An asynchronous reset during CALC_LO clears outputs without a clock edge.
        strobe(8'h01, 1'b0);
        ui_in  = 8'h02;
        uio_in = 8'h01;
        tick(1);
        uio_in = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_uo",  uo_out,  8'h00);
        check("arst_uio", uio_out, 8'h00);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("arst_idle_valid", {7'b0, uio_out[4]}, 8'h00);

        // Normal operation resumes after the reset.
        apply_stimulus("post_rst", vecs[2]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
